// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for an in-order core: merges ID load-use and EX multi-cycle stalls,
// runs the multi-cycle FSM and a registered redirect flush. Define STALL_STATS_EN for counters.
module pipe_stall_ctrl #(
  parameter int STAGES   = 6,
  parameter int ID_IDX   = 2,
  parameter int EX_IDX   = 3,
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                mc_done,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [STAGES-1:0]   stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                mc_busy
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [15:0]         flush_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_CNT  = 2'd1,
    MC_WAIT = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  function automatic logic [STAGES-1:0] low_mask(input int idx);
    logic [STAGES-1:0] m;
    for (int i = 0; i < STAGES; i++) m[i] = (i <= idx);
    return m;
  endfunction

  localparam logic [STAGES-1:0] EX_MASK = low_mask(EX_IDX);
  localparam logic [STAGES-1:0] ID_MASK = low_mask(ID_IDX);

  state_t              state, state_n;
  logic [MC_CNT_W-1:0] cnt, cnt_n;

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values in parallel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      new_pc <= 32'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (flush_req) new_pc <= flush_pc;
    end
  end

  // NOTE: defaults first in every always_comb, otherwise unassigned paths infer latches.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (mc_start) begin
          if (mc_cycles == '0) begin
            state_n = MC_WAIT;
          end else begin
            // The mc_start cycle is the first stall cycle; a 1-cycle op never leaves IDLE.
            cnt_n = mc_cycles - MC_CNT_W'(1);
            if (mc_cycles != MC_CNT_W'(1)) state_n = MC_CNT;
          end
        end
      end
      MC_CNT: begin
        if (mc_done || cnt <= MC_CNT_W'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - MC_CNT_W'(1);
        end
      end
      MC_WAIT: if (mc_done) state_n = IDLE;
      FLUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_req) begin
      state_n = FLUSH;
      cnt_n   = '0;
    end
  end

  // Mask is derived from registered state plus same-cycle requests only.
  always_comb begin
    stall = '0;
    if (state == FLUSH) begin
      stall = '0;
    end else if ((state == IDLE && mc_start) || (state == MC_CNT && cnt != '0) ||
                 state == MC_WAIT) begin
      stall = EX_MASK;
    end else if (stallreq_id) begin
      stall = ID_MASK;
    end
  end

  assign flush   = (state == FLUSH);
  assign mc_busy = (state != IDLE);

`ifdef STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall[0]) stall_cycles <= stall_cycles + 32'd1;
      if (flush)    flush_count  <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized bench for pipe_stall_ctrl against a remaining-cycles model of the stall rules.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, mc_start, mc_done, flush_req;
  logic [5:0]  mc_cycles;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush, mc_busy;
  logic [31:0] new_pc;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .mc_start(mc_start),
    .mc_cycles(mc_cycles), .mc_done(mc_done), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .mc_busy(mc_busy)
`ifdef STALL_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: stall cycles still owed after the current one, open-ended wait, pending flush.
  int          m_rem;
  bit          m_wait, m_flush;
  logic [31:0] m_pc;
  int          m_sc, m_fc;
  logic [5:0]  e_stall;
  bit          e_flush, e_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_wait = 0; m_flush = 0; m_pc = 32'h0; m_sc = 0; m_fc = 0;
  endtask

  task automatic clear_inputs();
    stallreq_id = 0; mc_start = 0; mc_cycles = '0; mc_done = 0; flush_req = 0; flush_pc = '0;
  endtask

  // Inputs are set by the caller; outputs checked at negedge, model advanced at posedge.
  task automatic step();
    @(negedge clk);
    e_flush = m_flush;
    e_busy  = m_flush || m_rem > 0 || m_wait;
    if (m_flush)                      e_stall = 6'b000000;
    else if (m_rem > 0 || m_wait)     e_stall = 6'b001111;
    else if (mc_start)                e_stall = 6'b001111;
    else if (stallreq_id)             e_stall = 6'b000111;
    else                              e_stall = 6'b000000;
    check("stall", 32'(stall), 32'(e_stall));
    check("flush", 32'(flush), 32'(e_flush));
    check("mc_busy", 32'(mc_busy), 32'(e_busy));
    if (e_flush) check("new_pc", new_pc, m_pc);
`ifdef STALL_STATS_EN
    check("stall_cycles", stall_cycles, 32'(m_sc));
    check("flush_count", 32'(flush_count), 32'(m_fc & 16'hFFFF));
`endif
    @(posedge clk);
    if (e_stall[0]) m_sc++;
    if (e_flush)    m_fc++;
    if (flush_req) begin
      m_flush = 1; m_rem = 0; m_wait = 0; m_pc = flush_pc;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_rem > 0) begin
      m_rem = mc_done ? 0 : m_rem - 1;
    end else if (m_wait) begin
      if (mc_done) m_wait = 0;
    end else if (mc_start) begin
      if (mc_cycles == 0) m_wait = 1;
      else m_rem = int'(mc_cycles) - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #12;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_busy", 32'(mc_busy), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (2) step();

    // Counted op of 4 cycles
    mc_start = 1; mc_cycles = 6'd4; step(); clear_inputs();
    repeat (5) step();

    // Open-ended op finished by mc_done in its 10th stall cycle
    mc_start = 1; mc_cycles = 6'd0; step(); clear_inputs();
    repeat (8) step();
    mc_done = 1; step(); mc_done = 0;
    repeat (2) step();

    // Load-use alone, then under a counted op, then a 1-cycle op
    stallreq_id = 1; step();
    mc_start = 1; mc_cycles = 6'd5; step(); mc_start = 0;
    repeat (5) step();
    clear_inputs();
    mc_start = 1; mc_cycles = 6'd1; step(); clear_inputs();
    repeat (2) step();

    // Flush during MC_WAIT, later stray mc_done
    mc_start = 1; mc_cycles = 6'd0; step(); clear_inputs();
    repeat (2) step();
    flush_req = 1; flush_pc = 32'hBFC00380; step(); clear_inputs();
    step();
    step();
    mc_done = 1; step(); clear_inputs();
    step();

    // Back-to-back flush requests retarget the redirect
    flush_req = 1; flush_pc = 32'h8000_0000; step();
    flush_pc = 32'h8000_0180; step(); clear_inputs();
    repeat (2) step();

    // Asynchronous reset in MC_CNT with the counter at 5
    mc_start = 1; mc_cycles = 6'd7; step(); clear_inputs();
    step();
    rst = 1'b1;
    #1;
    check("arst_stall", 32'(stall), 32'h0);
    check("arst_busy", 32'(mc_busy), 32'h0);
    check("arst_flush", 32'(flush), 32'h0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    repeat (2) step();

    // Statistics: 4-cycle op + 2 load-use cycles + 1 flush
    do_reset();
    mc_start = 1; mc_cycles = 6'd4; step(); clear_inputs();
    repeat (3) step();
    stallreq_id = 1; repeat (2) step(); clear_inputs();
    flush_req = 1; flush_pc = 32'h0000_1000; step(); clear_inputs();
    step();
`ifdef STALL_STATS_EN
    check("stats_stall_cycles", stall_cycles, 32'd6);
    check("stats_flush_count", 32'(flush_count), 32'd1);
`endif
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      stallreq_id = ($urandom_range(0, 2) == 0);
      mc_start    = ($urandom_range(0, 7) == 0);
      mc_cycles   = 6'($urandom_range(0, 6));
      mc_done     = ($urandom_range(0, 9) == 0);
      flush_req   = ($urandom_range(0, 24) == 0);
      flush_pc    = $urandom;
      step();
    end
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
